// File: rtl/draw_scheduler.sv
// draw_scheduler: round-robin arbiter that shares one square-raster engine
// between NREQ requesters. It latches the winning job, pulses eng_go for one
// cycle, waits for eng_done and then acks the requester.
// Optional feature macro: ERASE_FIRST_EN. When it is defined, each grant first
// erases the requester's previous square in BG_COLOUR, then draws the new one.
module draw_scheduler #(
  parameter int         NREQ      = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req,
  input  logic [10*NREQ-1:0] x_in,
  input  logic [10*NREQ-1:0] y_in,
  input  logic [10*NREQ-1:0] size_in,
  input  logic [3*NREQ-1:0]  colour_in,
  output logic [NREQ-1:0]    ack,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic               eng_go,
  output logic [9:0]         eng_x,
  output logic [9:0]         eng_y,
  output logic [9:0]         eng_size,
  output logic [2:0]         eng_colour,
  input  logic               eng_done
);

`ifdef ERASE_FIRST_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_HOLD = 3'd2, S_WAIT = 3'd3,
    S_ACK = 3'd4, S_ELOAD = 3'd5, S_EHOLD = 3'd6, S_EWAIT = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_HOLD = 3'd2, S_WAIT = 3'd3, S_ACK = 3'd4
  } state_t;
`endif

  state_t          state_r, state_next_s;
  logic [2:0]      ptr_r, grant_id_r, pick_s;
  logic [NREQ-1:0] ack_r, ack_next_s;
  logic            busy_r, busy_next_s, eng_go_r, go_next_s;
  logic [9:0]      eng_x_r, eng_y_r, eng_size_r;
  logic [2:0]      eng_colour_r;
  logic [9:0]      pick_x_s, pick_y_s, pick_size_s;
  logic [2:0]      pick_colour_s;

`ifdef ERASE_FIRST_EN
  logic [9:0]      sh_x_r [NREQ];
  logic [9:0]      sh_y_r [NREQ];
  logic [9:0]      sh_size_r [NREQ];
  logic [NREQ-1:0] sh_valid_r;
  logic [9:0]      job_x_r, job_y_r, job_size_r;
  logic [2:0]      job_colour_r;
  logic [9:0]      pick_sh_x_s, pick_sh_y_s, pick_sh_size_s;
  logic            pick_valid_s;
`endif

  // Round-robin pick: active request with the smallest distance after ptr
  always_comb begin
    int best_v;
    int dist_v;
    best_v = NREQ;
    dist_v = 0;
    pick_s = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (i > int'(ptr_r)) begin
        dist_v = i - int'(ptr_r) - 1;
      end else begin
        dist_v = i - int'(ptr_r) - 1 + NREQ;
      end
      if (req[i] && (dist_v < best_v)) begin
        best_v = dist_v;
        pick_s = 3'(i);
      end else begin
        best_v = best_v;
      end
    end
  end

  // Select the winner's job fields (and shadow copy), clamping size 0 to 1
  always_comb begin
    pick_x_s      = 10'd0;
    pick_y_s      = 10'd0;
    pick_size_s   = 10'd1;
    pick_colour_s = 3'd0;
`ifdef ERASE_FIRST_EN
    pick_sh_x_s    = 10'd0;
    pick_sh_y_s    = 10'd0;
    pick_sh_size_s = 10'd0;
    pick_valid_s   = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (pick_s == 3'(i)) begin
        pick_x_s      = x_in[10*i +: 10];
        pick_y_s      = y_in[10*i +: 10];
        pick_size_s   = (size_in[10*i +: 10] == 10'd0) ? 10'd1 : size_in[10*i +: 10];
        pick_colour_s = colour_in[3*i +: 3];
`ifdef ERASE_FIRST_EN
        pick_sh_x_s    = sh_x_r[i];
        pick_sh_y_s    = sh_y_r[i];
        pick_sh_size_s = sh_size_r[i];
        pick_valid_s   = sh_valid_r[i];
`endif
      end else begin
        pick_x_s = pick_x_s;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; eng_done only matters in the wait states
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (|req) begin
`ifdef ERASE_FIRST_EN
          state_next_s = pick_valid_s ? S_ELOAD : S_LOAD;
`else
          state_next_s = S_LOAD;
`endif
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD:  state_next_s = S_HOLD;
      S_HOLD:  state_next_s = S_WAIT;
      S_WAIT:  state_next_s = eng_done ? S_ACK : S_WAIT;
      S_ACK:   state_next_s = S_IDLE;
`ifdef ERASE_FIRST_EN
      S_ELOAD: state_next_s = S_EHOLD;
      S_EHOLD: state_next_s = S_EWAIT;
      S_EWAIT: state_next_s = eng_done ? S_LOAD : S_EWAIT;
`endif
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they can be registered
  always_comb begin
    ack_next_s  = '0;
    go_next_s   = (state_next_s == S_LOAD);
`ifdef ERASE_FIRST_EN
    go_next_s   = go_next_s || (state_next_s == S_ELOAD);
`endif
    busy_next_s = (state_next_s != S_IDLE);
    for (int i = 0; i < NREQ; i++) begin
      ack_next_s[i] = (state_next_s == S_ACK) && (grant_id_r == 3'(i));
    end
  end

  // Handshake outputs, job latch, engine fields and round-robin pointer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ack_r        <= '0;
      busy_r       <= 1'b0;
      eng_go_r     <= 1'b0;
      grant_id_r   <= 3'd0;
      ptr_r        <= 3'(NREQ - 1);
      eng_x_r      <= 10'd0;
      eng_y_r      <= 10'd0;
      eng_size_r   <= 10'd0;
      eng_colour_r <= 3'd0;
`ifdef ERASE_FIRST_EN
      job_x_r      <= 10'd0;
      job_y_r      <= 10'd0;
      job_size_r   <= 10'd0;
      job_colour_r <= 3'd0;
`endif
    end else begin
      ack_r    <= ack_next_s;
      busy_r   <= busy_next_s;
      eng_go_r <= go_next_s;
      if ((state_r == S_IDLE) && (|req)) begin
        grant_id_r <= pick_s;
`ifdef ERASE_FIRST_EN
        job_x_r      <= pick_x_s;
        job_y_r      <= pick_y_s;
        job_size_r   <= pick_size_s;
        job_colour_r <= pick_colour_s;
        if (pick_valid_s) begin
          eng_x_r      <= pick_sh_x_s;
          eng_y_r      <= pick_sh_y_s;
          eng_size_r   <= pick_sh_size_s;
          eng_colour_r <= BG_COLOUR;
        end else begin
          eng_x_r      <= pick_x_s;
          eng_y_r      <= pick_y_s;
          eng_size_r   <= pick_size_s;
          eng_colour_r <= pick_colour_s;
        end
      end else if ((state_r == S_EWAIT) && eng_done) begin
        eng_x_r      <= job_x_r;
        eng_y_r      <= job_y_r;
        eng_size_r   <= job_size_r;
        eng_colour_r <= job_colour_r;
`else
        eng_x_r      <= pick_x_s;
        eng_y_r      <= pick_y_s;
        eng_size_r   <= pick_size_s;
        eng_colour_r <= pick_colour_s;
`endif
      end else begin
        grant_id_r <= grant_id_r;
      end
      if (state_r == S_ACK) begin
        ptr_r <= grant_id_r;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

`ifdef ERASE_FIRST_EN
  // Shadow copy of each requester's last drawn square, captured at ack
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sh_valid_r <= '0;
      for (int i = 0; i < NREQ; i++) begin
        sh_x_r[i]    <= 10'd0;
        sh_y_r[i]    <= 10'd0;
        sh_size_r[i] <= 10'd0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if ((state_r == S_ACK) && (grant_id_r == 3'(i))) begin
          sh_x_r[i]     <= eng_x_r;
          sh_y_r[i]     <= eng_y_r;
          sh_size_r[i]  <= eng_size_r;
          sh_valid_r[i] <= 1'b1;
        end else begin
          sh_valid_r[i] <= sh_valid_r[i];
        end
      end
    end
  end
`endif

  assign ack        = ack_r;
  assign busy       = busy_r;
  assign grant_id   = grant_id_r;
  assign eng_go     = eng_go_r;
  assign eng_x      = eng_x_r;
  assign eng_y      = eng_y_r;
  assign eng_size   = eng_size_r;
  assign eng_colour = eng_colour_r;

endmodule
